dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: aligned loads/stores with
// read-modify-write for sub-word stores and fault reporting.
module dmem_access_ctrl #(
  parameter bit MISALIGN_FAULT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] Mem_Addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  input  logic [31:0] memory_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STORE  = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;
  localparam logic [2:0] FAULT  = 3'd6;

  logic [2:0]  state;
  logic [2:0]  idle_nxt;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic        mis;
  logic        bad;
  logic [1:0]  off;
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] ld_val;
  logic [31:0] bmask;
  logic [31:0] merged;
  logic        mem_act;

  always_comb begin
    mis = ((size == 2'b01) && addr[0]) ||
          ((size == 2'b10) && (addr[1:0] != 2'b00));
    bad = (size == 2'b11) || (MISALIGN_FAULT && mis);
    idle_nxt = IDLE;
    unique case (1'b1)
      bad:                               idle_nxt = FAULT;
      !bad && !is_store:                 idle_nxt = LOAD;
      !bad && is_store && size == 2'b10: idle_nxt = STORE;
      !bad && is_store && size != 2'b10: idle_nxt = RMW_RD;
    endcase
  end

  // Low address bits are forced to natural alignment when faults are off.
  always_comb begin
    case (size_q)
      2'b00:   off = addr_q[1:0];
      2'b01:   off = {addr_q[1], 1'b0};
      default: off = 2'b00;
    endcase
    sh   = {off, 3'b000};
    lane = memory_data >> sh;
    case (size_q)
      2'b00: begin
        ld_val = {{24{sext_q & lane[7]}}, lane[7:0]};
        bmask  = 32'h0000_00ff;
      end
      2'b01: begin
        ld_val = {{16{sext_q & lane[15]}}, lane[15:0]};
        bmask  = 32'h0000_ffff;
      end
      default: begin
        ld_val = memory_data;
        bmask  = 32'hffff_ffff;
      end
    endcase
    merged = (merge_q & ~(bmask << sh)) | ((wdata_q & bmask) << sh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr;
            wdata_q <= wdata;
            state   <= idle_nxt;
          end
        end
        LOAD: begin
          rdata <= ld_val;
          state <= RESP;
        end
        STORE:  state <= RESP;
        RMW_RD: begin
          merge_q <= memory_data;
          state   <= RMW_WR;
        end
        RMW_WR: state <= RESP;
        RESP:   state <= IDLE;
        FAULT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the strobes so an aborted access never writes or completes.
  always_comb begin
    mem_act = (state == LOAD) || (state == STORE) ||
              (state == RMW_RD) || (state == RMW_WR);
    Mem_Addr = mem_act ? {addr_q[31:2], 2'b00} : 32'd0;
    case (state)
      STORE:   mem_wdata = wdata_q;
      RMW_WR:  mem_wdata = merged;
      default: mem_wdata = 32'd0;
    endcase
    mem_wen = ((state == STORE) || (state == RMW_WR)) && !reset;
    busy    = (state != IDLE);
    done    = ((state == RESP) || (state == FAULT)) && !reset;
    fault   = (state == FAULT) && !reset;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a small
// word-addressed DMEM model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] Mem_Addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] memory_data;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;

  logic [31:0] dmem [0:15];
  int          cyc = 0;
  int          wen_cnt = 0;
  logic [31:0] wen_addr = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        flt;
    logic [31:0] rd;
    int          due;
  } exp_t;
  exp_t q[$];

  dmem_access_ctrl #(.MISALIGN_FAULT(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .is_store(is_store),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .Mem_Addr(Mem_Addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .memory_data(memory_data), .busy(busy), .done(done),
    .rdata(rdata), .fault(fault)
  );

  always #5 clk = ~clk;

  assign memory_data = dmem[Mem_Addr[5:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wen) begin
      dmem[Mem_Addr[5:2]] <= mem_wdata;
      wen_cnt  <= wen_cnt + 1;
      wen_addr <= Mem_Addr;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pops one expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d want none",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fault", {31'd0, fault}, {31'd0, e.flt});
        chk("rdata", rdata, e.rd);
        chk("latency", cyc, e.due);
      end
    end
  end

  task automatic drive(input logic st, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a,
                       input logic [31:0] wd);
    req      = 1'b1;
    is_store = st;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wdata    = wd;
  endtask

  task automatic op(input logic st, input logic [1:0] sz,
                    input logic sx, input logic [31:0] a,
                    input logic [31:0] wd, input logic flt,
                    input logic [31:0] rd, input int lat);
    exp_t e;
    @(negedge clk);
    drive(st, sz, sx, a, wd);
    e.flt = flt;
    e.rd  = rd;
    e.due = cyc + lat;
    q.push_back(e);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 8 && !done; i++) @(negedge clk);
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no done want done at %0d", e.due);
    end
  endtask

  initial begin
    int w0;
    int nd;
    exp_t e;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", Mem_Addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    op(1, 2'b10, 0, 32'd8, 32'd511, 0, 32'd0, 2);
    chk("sw_wen_cnt", wen_cnt, 32'd1);
    chk("sw_wen_addr", wen_addr, 32'd8);
    chk("sw_mem", dmem[2], 32'd511);
    op(0, 2'b10, 0, 32'd8, 32'd0, 0, 32'd511, 2);

    op(1, 2'b10, 0, 32'd8, 32'h1122_3344, 0, 32'd511, 2);
    w0 = wen_cnt;
    op(1, 2'b00, 0, 32'd9, 32'h0000_00ab, 0, 32'd511, 3);
    chk("sb_mem", dmem[2], 32'h1122_ab44);
    chk("sb_wen_cnt", wen_cnt, w0 + 1);

    op(1, 2'b10, 0, 32'd12, 32'h80ff_0080, 0, 32'd511, 2);
    op(0, 2'b00, 1, 32'd12, 32'd0, 0, 32'hffff_ff80, 2);
    op(0, 2'b01, 0, 32'd14, 32'd0, 0, 32'h0000_80ff, 2);
    op(0, 2'b00, 0, 32'd12, 32'd0, 0, 32'h0000_0080, 2);
    op(0, 2'b00, 1, 32'd15, 32'd0, 0, 32'hffff_ff80, 2);
    op(0, 2'b01, 1, 32'd12, 32'd0, 0, 32'h0000_0080, 2);
    op(0, 2'b00, 1, 32'd13, 32'd0, 0, 32'h0000_0000, 2);

    op(1, 2'b01, 0, 32'd14, 32'h1234_beef, 0, 32'h0000_0000, 3);
    chk("sh_mem", dmem[3], 32'hbeef_0080);
    op(0, 2'b10, 0, 32'd12, 32'd0, 0, 32'hbeef_0080, 2);

    w0 = wen_cnt;
    op(0, 2'b10, 0, 32'd6, 32'd0, 1, 32'hbeef_0080, 1);
    op(0, 2'b11, 0, 32'd0, 32'd0, 1, 32'hbeef_0080, 1);
    op(1, 2'b01, 0, 32'd9, 32'h5555, 1, 32'hbeef_0080, 1);
    op(1, 2'b10, 0, 32'd10, 32'h6666, 1, 32'hbeef_0080, 1);
    chk("flt_no_wen", wen_cnt, w0);
    chk("flt_mem", dmem[2], 32'h1122_ab44);

    // Reset while the RMW read is in flight
    @(negedge clk);
    drive(1, 2'b00, 0, 32'd9, 32'h0000_00cd);
    @(negedge clk);
    req = 1'b0;
    chk("rmw_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_wen", {31'd0, mem_wen}, 32'd0);
    chk("abort_addr", Mem_Addr, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_wen", wen_cnt, w0);
    chk("abort_mem", dmem[2], 32'h1122_ab44);
    op(0, 2'b10, 0, 32'd8, 32'd0, 0, 32'h1122_ab44, 2);

    // Reset arriving in the STORE cycle must suppress the write
    @(negedge clk);
    drive(1, 2'b10, 0, 32'd8, 32'hdead_beef);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b1;
    #1;
    chk("st_rst_wen", {31'd0, mem_wen}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("st_rst_mem", dmem[2], 32'h1122_ab44);
    chk("st_rst_cnt", wen_cnt, w0);

    // req held high: two back-to-back loads, second starts after done
    @(negedge clk);
    drive(0, 2'b10, 0, 32'd12, 32'd0);
    e.flt = 1'b0;
    e.rd  = 32'hbeef_0080;
    e.due = cyc + 2;
    q.push_back(e);
    e.due = cyc + 5;
    q.push_back(e);
    nd = 0;
    for (int i = 0; i < 20 && nd < 2; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    req = 1'b0;
    chk("held_dones", nd, 32'd2);
    repeat (4) @(negedge clk);
    chk("held_no_wen", wen_cnt, w0);
    chk("queue_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
